// File: rtl/modified_alu_pkg.sv
// Shared definitions for the modified_alu_nbit execute-stage ALU.
// Holds the 4-bit operation-select encodings used by the core decoder
// and by anything that drives the Mode input.
package modified_alu_pkg;

  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] MODE_ADD  = 4'b0000;
  localparam logic [MODE_W-1:0] MODE_SUB  = 4'b0001;
  localparam logic [MODE_W-1:0] MODE_INC  = 4'b0010;
  localparam logic [MODE_W-1:0] MODE_DEC  = 4'b0011;
  localparam logic [MODE_W-1:0] MODE_AND  = 4'b0100;
  localparam logic [MODE_W-1:0] MODE_OR   = 4'b0101;
  localparam logic [MODE_W-1:0] MODE_XOR  = 4'b0110;
  localparam logic [MODE_W-1:0] MODE_XNOR = 4'b0111;
  localparam logic [MODE_W-1:0] MODE_NAND = 4'b1000;
  localparam logic [MODE_W-1:0] MODE_NOR  = 4'b1001;
  localparam logic [MODE_W-1:0] MODE_NOTA = 4'b1010;
  localparam logic [MODE_W-1:0] MODE_NOTB = 4'b1011;
  localparam logic [MODE_W-1:0] MODE_SHL  = 4'b1100;
  localparam logic [MODE_W-1:0] MODE_SHR  = 4'b1101;
  localparam logic [MODE_W-1:0] MODE_ROL  = 4'b1110;
  localparam logic [MODE_W-1:0] MODE_ROR  = 4'b1111;

endpackage

// File: rtl/modified_alu_core.sv
// Combinational datapath of the N-bit ALU: decodes Mode and produces the
// next result and next carry/borrow/shift-out flag.
// Ports:
//   A, B        : N-bit unsigned operands
//   CB_in       : carry-in (ADD) / borrow-in (SUB), unused otherwise
//   Mode        : 4-bit operation select
//   result_next : N-bit result of the selected operation
//   cb_out_next : carry, borrow or shifted-out bit (0 for logic modes)
module modified_alu_core
  import modified_alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic              CB_in,
  input  logic [MODE_W-1:0] Mode,
  output logic [N-1:0]      result_next,
  output logic              cb_out_next
);

  // One spare bit on top catches the carry (or, for subtraction, the
  // sign of the wrapped difference, which is exactly the borrow).
  logic [N:0] wide;

  // CB_in appears only in the ADD and SUB arms, so an unknown CB_in
  // cannot reach the outputs in any other mode.
  always_comb begin
    wide        = '0;
    result_next = '0;
    cb_out_next = 1'b0;
    case (Mode)
      MODE_ADD: begin
        wide        = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, CB_in};
        result_next = wide[N-1:0];
        cb_out_next = wide[N];
      end
      MODE_SUB: begin
        wide        = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, CB_in};
        result_next = wide[N-1:0];
        cb_out_next = wide[N];
      end
      MODE_INC: begin
        wide        = {1'b0, A} + {{N{1'b0}}, 1'b1};
        result_next = wide[N-1:0];
        cb_out_next = wide[N];
      end
      MODE_DEC: begin
        wide        = {1'b0, A} - {{N{1'b0}}, 1'b1};
        result_next = wide[N-1:0];
        cb_out_next = wide[N];
      end
      MODE_AND:  result_next = A & B;
      MODE_OR:   result_next = A | B;
      MODE_XOR:  result_next = A ^ B;
      MODE_XNOR: result_next = ~(A ^ B);
      MODE_NAND: result_next = ~(A & B);
      MODE_NOR:  result_next = ~(A | B);
      MODE_NOTA: result_next = ~A;
      MODE_NOTB: result_next = ~B;
      MODE_SHL: begin
        result_next = {A[N-2:0], 1'b0};
        cb_out_next = A[N-1];
      end
      MODE_SHR: begin
        result_next = {1'b0, A[N-1:1]};
        cb_out_next = A[0];
      end
      MODE_ROL: begin
        result_next = {A[N-2:0], A[N-1]};
        cb_out_next = A[N-1];
      end
      MODE_ROR: begin
        result_next = {A[0], A[N-1:1]};
        cb_out_next = A[0];
      end
      default: begin
        result_next = '0;
        cb_out_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/modified_alu_nbit.sv
// N-bit ALU with a registered output (one clock of latency, one operation
// per clock). The combinational work lives in modified_alu_core; this
// level only adds the output register with asynchronous reset.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears Result and CB_out
//   A, B   : N-bit unsigned operands
//   CB_in  : carry-in (ADD) / borrow-in (SUB)
//   Mode   : 4-bit operation select
//   Result : registered N-bit result
//   CB_out : registered carry/borrow/shift-out flag
module modified_alu_nbit
  import modified_alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic              CB_in,
  input  logic [MODE_W-1:0] Mode,
  output logic [N-1:0]      Result,
  output logic              CB_out
);

  logic [N-1:0] result_p0;
  logic         cb_p0;

  modified_alu_core #(
    .N (N)
  ) u_core (
    .A           (A),
    .B           (B),
    .CB_in       (CB_in),
    .Mode        (Mode),
    .result_next (result_p0),
    .cb_out_next (cb_p0)
  );

  // Stage p0 -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result <= '0;
      CB_out <= 1'b0;
    end else begin
      Result <= result_p0;
      CB_out <= cb_p0;
    end
  end

endmodule

// File: tb/tb_modified_alu_nbit.sv
module tb_modified_alu_nbit;
  import modified_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, mode4 = '0;
  logic       cin4 = 1'b0;
  logic [3:0] res4;
  logic       cb4;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] mode8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] res8;
  logic       cb8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modified_alu_nbit #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .CB_in(cin4), .Mode(mode4),
    .Result(res4), .CB_out(cb4)
  );

  modified_alu_nbit #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .CB_in(cin8), .Mode(mode8),
    .Result(res8), .CB_out(cb8)
  );

  typedef struct {
    logic [3:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] res;
    logic       cb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [3:0] r, input logic cb);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.cin = c; v.res = r; v.cb = cb;
    vecs.push_back(v);
  endtask

  // Independent reference for the 8-bit instance, written with integers.
  function automatic logic [8:0] ref8(input logic [3:0] m, input int a, input int b, input int c);
    int r;
    int f;
    r = 0; f = 0;
    case (m)
      MODE_ADD:  begin r = (a + b + c) % 256; f = (a + b + c > 255) ? 1 : 0; end
      MODE_SUB:  begin r = (a - b - c + 512) % 256; f = (a < b + c) ? 1 : 0; end
      MODE_INC:  begin r = (a + 1) % 256; f = (a == 255) ? 1 : 0; end
      MODE_DEC:  begin r = (a + 255) % 256; f = (a == 0) ? 1 : 0; end
      MODE_AND:  r = a & b;
      MODE_OR:   r = a | b;
      MODE_XOR:  r = a ^ b;
      MODE_XNOR: r = 255 - (a ^ b);
      MODE_NAND: r = 255 - (a & b);
      MODE_NOR:  r = 255 - (a | b);
      MODE_NOTA: r = 255 - a;
      MODE_NOTB: r = 255 - b;
      MODE_SHL:  begin r = (a * 2) % 256; f = a / 128; end
      MODE_SHR:  begin r = a / 2; f = a % 2; end
      MODE_ROL:  begin r = (a * 2) % 256 + a / 128; f = a / 128; end
      MODE_ROR:  begin r = a / 2 + (a % 2) * 128; f = a % 2; end
      default:   begin r = 0; f = 0; end
    endcase
    return {f[0], r[7:0]};
  endfunction

  initial begin
    logic [8:0] exp8;
    // Arithmetic
    add(MODE_ADD, 4'b0000, 4'b0101, 1'b0, 4'b0101, 1'b0);
    add(MODE_ADD, 4'b1111, 4'b1010, 1'b0, 4'b1001, 1'b1);
    add(MODE_ADD, 4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1);
    add(MODE_ADD, 4'b0010, 4'b0011, 1'b1, 4'b0110, 1'b0);
    add(MODE_SUB, 4'b1100, 4'b0101, 1'b0, 4'b0111, 1'b0);
    add(MODE_SUB, 4'b0001, 4'b0011, 1'b1, 4'b1101, 1'b1);
    add(MODE_SUB, 4'b0101, 4'b0100, 1'b1, 4'b0000, 1'b0);
    add(MODE_SUB, 4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1);
    add(MODE_INC, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1);
    add(MODE_INC, 4'b0110, 4'b0000, 1'b1, 4'b0111, 1'b0);
    add(MODE_DEC, 4'b0000, 4'b1111, 1'b1, 4'b1111, 1'b1);
    add(MODE_DEC, 4'b1011, 4'b0000, 1'b1, 4'b1010, 1'b0);
    // Logic, complementary operands
    add(MODE_AND,  4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b0);
    add(MODE_OR,   4'b1010, 4'b0101, 1'b1, 4'b1111, 1'b0);
    add(MODE_XOR,  4'b1010, 4'b0101, 1'b1, 4'b1111, 1'b0);
    add(MODE_XNOR, 4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b0);
    add(MODE_NAND, 4'b1010, 4'b0101, 1'b1, 4'b1111, 1'b0);
    add(MODE_NOR,  4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b0);
    add(MODE_NOTA, 4'b1010, 4'b0101, 1'b1, 4'b0101, 1'b0);
    add(MODE_NOTB, 4'b1010, 4'b0101, 1'b1, 4'b1010, 1'b0);
    // Logic, overlapping operands
    add(MODE_AND,  4'b1100, 4'b1010, 1'b1, 4'b1000, 1'b0);
    add(MODE_OR,   4'b1100, 4'b1010, 1'b1, 4'b1110, 1'b0);
    add(MODE_XOR,  4'b1100, 4'b1010, 1'b1, 4'b0110, 1'b0);
    add(MODE_XNOR, 4'b1100, 4'b1010, 1'b1, 4'b1001, 1'b0);
    add(MODE_NAND, 4'b1100, 4'b1010, 1'b1, 4'b0111, 1'b0);
    add(MODE_NOR,  4'b1100, 4'b1010, 1'b1, 4'b0001, 1'b0);
    add(MODE_NOTA, 4'b1100, 4'b1010, 1'b1, 4'b0011, 1'b0);
    add(MODE_NOTB, 4'b1100, 4'b1010, 1'b1, 4'b0101, 1'b0);
    // Shift / rotate
    add(MODE_SHL, 4'b1011, 4'b1111, 1'b1, 4'b0110, 1'b1);
    add(MODE_SHR, 4'b1011, 4'b1111, 1'b1, 4'b0101, 1'b1);
    add(MODE_ROL, 4'b1011, 4'b1111, 1'b1, 4'b0111, 1'b1);
    add(MODE_ROR, 4'b1011, 4'b1111, 1'b1, 4'b1101, 1'b1);
    add(MODE_SHL, 4'b0100, 4'b0000, 1'b1, 4'b1000, 1'b0);
    add(MODE_SHR, 4'b0100, 4'b0000, 1'b1, 4'b0010, 1'b0);
    add(MODE_ROL, 4'b0100, 4'b0000, 1'b1, 4'b1000, 1'b0);
    add(MODE_ROR, 4'b0100, 4'b0000, 1'b1, 4'b0010, 1'b0);

    // Reset held: outputs zero, even across clock edges
    #2;
    chk("reset_hold_res", {5'b0, res4}, 9'h000);
    chk("reset_hold_cb", {8'b0, cb4}, 9'h000);
    mode4 = MODE_ADD; a4 = 4'b0011; b4 = 4'b0100;
    @(posedge clk); #1;
    chk("reset_edge_res", {5'b0, res4}, 9'h000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("pre_async_res", {cb4, 1'b0, res4}, {1'b0, 4'b0, 4'b0111});
    // Asynchronous assertion between edges, in-flight op discarded
    a4 = 4'b1111; b4 = 4'b1111;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_res", {5'b0, res4}, 9'h000);
    chk("async_rst_cb", {8'b0, cb4}, 9'h000);
    @(posedge clk); #1;
    chk("async_rst_hold", {cb4, 4'b0, res4}, 9'h000);
    @(negedge clk); rst = 1'b0;
    a4 = '0; b4 = '0;

    // Directed table, back-to-back one vector per cycle
    foreach (vecs[i]) begin
      mode4 = vecs[i].mode; a4 = vecs[i].a; b4 = vecs[i].b; cin4 = vecs[i].cin;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_m%b_res", i, vecs[i].mode), {5'b0, res4}, {5'b0, vecs[i].res});
      chk($sformatf("vec%0d_m%b_cb", i, vecs[i].mode), {8'b0, cb4}, {8'b0, vecs[i].cb});
    end

    // Non-arithmetic modes with an unknown carry-in
    foreach (vecs[i]) begin
      if (vecs[i].mode >= MODE_INC) begin
        mode4 = vecs[i].mode; a4 = vecs[i].a; b4 = vecs[i].b; cin4 = 1'bx;
        @(posedge clk); #1;
        chk($sformatf("xcin%0d_m%b", i, vecs[i].mode), {cb4, 4'b0, res4},
            {vecs[i].cb, 4'b0, vecs[i].res});
      end
    end
    cin4 = 1'b0;

    // 8-bit instance: every mode, operands changing each cycle
    for (int k = 0; k < 64; k++) begin
      mode8 = k[3:0];
      a8 = (k % 16 == 0) ? 8'h00 : (k % 16 == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      exp8 = ref8(mode8, int'(a8), int'(b8), int'(cin8));
      @(posedge clk); #1;
      chk($sformatf("n8_k%0d_m%b", k, mode8), {cb8, res8}, exp8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
